// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ITER  = 2'b01,
    FIXUP = 2'b10,
    DONE  = 2'b11
  } div_state_e;

  // Quotient reported on divide-by-zero; sliced to WIDTH by the user (WIDTH <= 64).
  localparam logic [63:0] DIV0_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {A,Q} left, trial-subtract M from A.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] m_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] a_shift;
  logic [WIDTH:0] diff;

  always_comb begin
    // The shifted A needs WIDTH+1 bits; its MSB feeds the trial subtraction.
    a_shift = {a_in, q_in[WIDTH-1]};
    diff    = a_shift - {1'b0, m_in};
    if (!diff[WIDTH]) begin
      a_out = diff[WIDTH-1:0];
      q_out = {q_in[WIDTH-2:0], 1'b1};
    end else begin
      a_out = a_shift[WIDTH-1:0];
      q_out = {q_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Define SIGNED_DIV_EN for two's-complement operands (adds a FIXUP cycle).
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] a_step, q_step;
  logic [WIDTH-1:0] dividend_mag, divisor_mag;

`ifdef SIGNED_DIV_EN
  logic neg_quot_q, neg_quot_d;
  logic neg_rem_q, neg_rem_d;

  always_comb begin
    dividend_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    divisor_mag  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
  end
`else
  always_comb begin
    dividend_mag = dividend;
    divisor_mag  = divisor;
  end
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .a_in  (a_q),
    .q_in  (q_q),
    .m_in  (m_q),
    .a_out (a_step),
    .q_out (q_step)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef SIGNED_DIV_EN
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (divisor == '0) begin
            quot_d  = DIV0_QUOT[WIDTH-1:0];
            rem_d   = dividend;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            a_d     = '0;
            q_d     = dividend_mag;
            m_d     = divisor_mag;
            count_d = CNT_W'(WIDTH);
            dbz_d   = 1'b0;
            state_d = ITER;
`ifdef SIGNED_DIV_EN
            neg_quot_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d  = dividend[WIDTH-1];
`endif
          end
        end
      end

      ITER: begin
        a_d     = a_step;
        q_d     = q_step;
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          quot_d = q_step;
          rem_d  = a_step;
`ifdef SIGNED_DIV_EN
          state_d = FIXUP;
`else
          state_d = DONE;
          done_d  = 1'b1;
`endif
        end
      end

`ifdef SIGNED_DIV_EN
      FIXUP: begin
        // Negating 2^(WIDTH-1) wraps to itself, which gives the overflow result.
        if (neg_quot_q) quot_d = ~quot_q + 1'b1;
        if (neg_rem_q)  rem_d  = ~rem_q + 1'b1;
        state_d = DONE;
        done_d  = 1'b1;
      end
`endif

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a monitor checks on done.
module tb_seq_divider;

  localparam int W = 8;
`ifdef SIGNED_DIV_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int unsigned  cyc;
    string        name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, " quotient"}, 32'(quotient), 32'(e.q));
        check({e.name, " remainder"}, 32'(remainder), 32'(e.r));
        check({e.name, " div_by_zero"}, 32'(div_by_zero), 32'(e.z));
        check({e.name, " latency_cycle"}, cyc, e.cyc);
      end
    end
  end

  task automatic issue(input string name, input logic [W-1:0] dd, input logic [W-1:0] ds,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                       input int unsigned lat);
    exp_t e;
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL %s idle_wait: got busy=%b expected 0 within 50 cycles", name, busy);
    end
    start    = 1'b1;
    dividend = dd;
    divisor  = ds;
    e.q = eq; e.r = er; e.z = ez; e.cyc = cyc + 1 + lat; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'hA5;
    divisor  = 8'h00;
    check({name, " busy_after_accept"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string name);
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s done_timeout: got %0d pending results expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input string name, input logic [W-1:0] dd, input logic [W-1:0] ds,
                     input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                     input int unsigned lat);
    issue(name, dd, ds, eq, er, ez, lat);
    wait_done(name);
  endtask

  initial begin
    int unsigned base;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    run("100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, LAT);
    run("5/0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 0);
    run("9/3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, LAT);
    run("3/10", 8'd3, 8'd10, 8'd0, 8'd3, 1'b0, LAT);
    // Bit patterns chosen so the expected results agree in signed mode.
    run("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, LAT);
    run("255/255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, LAT);
    @(negedge clk);
    check("busy_low_after_done", 32'(busy), 32'd0);

    base = done_cnt;
    issue("100/7_ignore", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, LAT);
    repeat (2) @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done("100/7_ignore");
    repeat (12) @(negedge clk);
    check("single_done_pulse", done_cnt - base, 32'd1);

    base = done_cnt;
    issue("100/7_reset", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, LAT);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst quotient", 32'(quotient), 32'd0);
    check("midrst remainder", 32'(remainder), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst dbz", 32'(div_by_zero), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("no_done_after_reset", done_cnt - base, 32'd0);
    run("20/6", 8'd20, 8'd6, 8'd3, 8'd2, 1'b0, LAT);

`ifdef SIGNED_DIV_EN
    run("-7/2", 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, LAT);
    run("-128/-1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, LAT);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected completion earlier", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring divider; the inverse-operation companion to the team's Booth multiplier controller.
- Combines FSM control with an A/Q/M register datapath in one block.
- Accepts a dividend/divisor pair on a start pulse and iterates one quotient bit per clock.
- Returns quotient, remainder and a divide-by-zero flag with a one-cycle done pulse; it sits beside the multiplier in the arithmetic unit.

Parameters:
- WIDTH, 8, operand/quotient/remainder width in bits (>=2).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  numerator, sampled with start.
- divisor  input  WIDTH  denominator, sampled with start.
- busy  output  1  high from the edge that accepts start until the edge that leaves DONE.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  WIDTH  result; held until the next accepted start.
- remainder  output  WIDTH  result; held until the next accepted start.
- div_by_zero  output  1  set with done when divisor==0; held like the results.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, A=0, Q=0, M=0, count=0, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. Reset mid-operation abandons the division; no done is produced.
- States: IDLE, ITER, FIXUP (only with the optional feature), DONE.
- IDLE:
  - start=1 and divisor!=0 -> load A=0, Q=dividend, M=divisor, count=WIDTH, clear div_by_zero, busy=1, go to ITER.
  - start=1 and divisor==0 -> quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1, busy=1, go to DONE.
- ITER, one iteration per edge:
  - {A,Q} shifted left 1.
  - diff = A_shifted - M, computed at WIDTH+1 bits.
  - diff non-negative -> A=diff[WIDTH-1:0], Q[0]=1; else A keeps the shifted value, Q[0]=0.
  - count decrements.
  - On the edge where count goes 1->0: quotient<=Q_new, remainder<=A_new, go to DONE (or FIXUP).
- DONE: done=1 for exactly this one cycle; next edge -> IDLE, busy=0, done=0.
- Latency: start accepted at edge E0; done is high in the cycle after edge E_WIDTH (after E_WIDTH+1 with FIXUP). Divide-by-zero: done is high in the cycle after E0.
- start while busy is ignored. start high in the DONE cycle is ignored. start held high in IDLE after DONE starts a new division.
- Back-to-back: earliest next accept is the edge after DONE.
- Operand inputs are don't-care except at the accepting edge.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- Defined:
  - Operands are two's complement.
  - IDLE loads magnitudes |dividend| and |divisor|, and records sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - After ITER the FSM enters FIXUP (1 cycle), which negates the quotient if sign_q and the remainder if sign_r, then goes to DONE.
  - Overflow case -2^(WIDTH-1) / -1 yields quotient -2^(WIDTH-1) (wrap) and remainder 0; no flag.
  - Divide-by-zero behaves as in unsigned mode (quotient all-ones, remainder=dividend).
- Undefined: unsigned operation only; FIXUP state and sign registers are absent; latency is WIDTH.

Decomposition:
- Package div_pkg:
  - State enum (IDLE=2'b00, ITER=2'b01, FIXUP=2'b10, DONE=2'b11).
  - Localparam DIV0_QUOT = all-ones.
- One natural combinational sub-module, div_step: inputs A, Q, M; outputs next A, next Q. It implements a single shift/trial-subtract iteration.
- FSM, counter and output registers stay in seq_divider.

Test Plan:
- WIDTH=8, dividend=100, divisor=7, start 1 cycle -> busy next cycle; done after 8 edges; quotient=14, remainder=2, div_by_zero=0.
- dividend=5, divisor=0 -> done 1 edge after accept; quotient=0xFF, remainder=5, div_by_zero=1; next division 9/3 clears flag, gives quotient=3, remainder=0.
- Boundary: 255/1 -> quotient=255, remainder=0; 3/10 -> quotient=0, remainder=3; 255/255 -> quotient=1, remainder=0.
- Pulse start with 50/5 during ITER of 100/7 -> ignored; results 14/2; exactly one done pulse.
- Assert rst at iteration 4 of 100/7 -> all outputs 0 immediately, no done; then 20/6 -> quotient=3, remainder=2.
- SIGNED_DIV_EN: -7/2 -> quotient=0xFD, remainder=0xFF, latency 9; -128/-1 -> quotient=0x80, remainder=0.
